// File: rtl/au_seq.sv
// rtl/au_seq.sv - command sequencer owning the control side of the 8-bit arithmetic unit
module au_seq #(
  parameter int W    = 8,
  parameter int NREG = 4,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_rs,
  input  logic [W-1:0]  cmd_imm,
  output logic          au_en,
  output logic [3:0]    ac,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  input  logic [W-1:0]  t,
  input  logic          gf,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_gf,
  output logic          rsp_err,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam logic [3:0] OP_RD  = 4'b0001;

  state_t        state;
  logic [W-1:0]  regs [NREG];
  logic [RW-1:0] rd_q;

  function automatic logic is_au_op(input logic [3:0] op);
    case (op)
      4'b1000, 4'b1001, 4'b0100, 4'b0101, 4'b1101: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // rsp_gf doubles as the flag register; it only moves at the ISSUE writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      rd_q      <= '0;
      au_en     <= 1'b0;
      ac        <= 4'b0000;
      a         <= '0;
      b         <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_gf    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rd_q      <= cmd_rd;
            rsp_err   <= 1'b0;
            if (is_au_op(cmd_op)) begin
              state <= ISSUE;
              au_en <= 1'b1;
              ac    <= cmd_op;
              a     <= regs[cmd_rs];
              b     <= regs[cmd_rd];
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              case (cmd_op)
                OP_LDI: begin
                  regs[cmd_rd] <= cmd_imm;
                  rsp_data     <= cmd_imm;
                end
                OP_RD:   rsp_data <= regs[cmd_rd];
                default: begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
                end
              endcase
            end
          end
        end
        ISSUE: begin
          au_en      <= 1'b0;
          ac         <= 4'b0000;
          a          <= '0;
          b          <= '0;
          regs[rd_q] <= t;
          rsp_gf     <= gf;
          rsp_data   <= t;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_au_seq.sv
// tb/tb_au_seq.sv - scoreboard bench for au_seq with a behavioural AU and register-file model
module tb_au_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'b0;
  logic [1:0] cmd_rd = 2'b0;
  logic [1:0] cmd_rs = 2'b0;
  logic [7:0] cmd_imm = 8'h0;
  logic       au_en;
  logic [3:0] ac;
  logic [7:0] a, b;
  wire  [7:0] t;
  wire        gf;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_gf, rsp_err, busy;

  always #5 clk = ~clk;

  au_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .au_en(au_en), .ac(ac), .a(a), .b(b), .t(t), .gf(gf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_gf(rsp_gf), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural AU: b is the destination operand, a the source.
  logic [7:0] au_t;
  logic       au_gf;
  always_comb begin
    au_t  = a;
    au_gf = 1'b0;
    case (ac)
      4'b1000: au_t = a + b;
      4'b1001: begin au_t = b - a; au_gf = (b > a); end
      default: au_t = a;
    endcase
  end
  assign t  = au_en ? au_t : 8'bz;
  assign gf = au_en ? au_gf : 1'b0;

  typedef struct packed { logic [7:0] d; logic g; logic e; } rsp_t;
  rsp_t exp_q[$];

  logic [7:0] mreg [4];
  logic       mflag;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         force_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mflag = 1'b0;
  endtask

  function automatic bit is_au(input logic [3:0] op);
    return (op == 4'h8) || (op == 4'h9) || (op == 4'h4) || (op == 4'h5) || (op == 4'hD);
  endfunction

  task automatic send(input logic [3:0] op, input int rd, input int rs, input logic [7:0] imm,
                      input bit abort = 0);
    int         guard = 0;
    logic [7:0] d, ea, eb;
    logic       g, e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd[1:0]; cmd_rs = rs[1:0]; cmd_imm = imm;
    while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      chk("cmd_accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    ea = mreg[rs]; eb = mreg[rd];
    g = mflag; e = 1'b0;
    case (op)
      4'h8:             begin d = mreg[rd] + mreg[rs]; g = 1'b0; end
      4'h9:             begin d = mreg[rd] - mreg[rs]; g = (mreg[rd] > mreg[rs]); end
      4'h4, 4'h5, 4'hD: begin d = mreg[rs]; g = 1'b0; end
      4'h0:             d = imm;
      4'h1:             d = mreg[rd];
      default:          begin d = 8'h00; e = 1'b1; end
    endcase
    if (!abort) begin
      if (is_au(op) || op == 4'h0) mreg[rd] = d;
      mflag = g;
      exp_q.push_back('{d: d, g: g, e: e});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    if (is_au(op)) begin
      chk("issue_au_en", 32'(au_en), 32'd1);
      chk("issue_ac", 32'(ac), 32'(op));
      chk("issue_a", 32'(a), 32'(ea));
      chk("issue_b", 32'(b), 32'(eb));
      chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
      if (abort) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_au_en", 32'(au_en), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        chk("abort_rsp_valid_held", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        return;
      end
      @(negedge clk);
      chk("au_latency_rsp_valid", 32'(rsp_valid), 32'd1);
    end else begin
      chk("local_latency_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("local_au_en", 32'(au_en), 32'd0);
    end
  endtask

  // Monitor: drives rsp_ready, checks stability while stalled, pops on handshake.
  initial begin
    bit         seen = 0;
    int         stall = 0;
    logic [7:0] hd;
    logic       hg, he;
    rsp_t       ex;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("resp_au_en", 32'(au_en | (|ac) | (|a) | (|b)), 32'd0);
        if (!seen) begin
          seen = 1; hd = rsp_data; hg = rsp_gf; he = rsp_err;
          stall = force_stall ? 3 : int'($urandom_range(0, 2));
          force_stall = 0;
        end else begin
          chk("stall_stable", {rsp_data, rsp_gf, rsp_err}, {hd, hg, he});
        end
        if (stall > 0) begin
          stall--;
          rsp_ready = 1'b0;
        end else begin
          rsp_ready = 1'b1;
          seen = 0;
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            ex = exp_q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(ex.d));
            chk("rsp_gf", 32'(rsp_gf), 32'(ex.g));
            chk("rsp_err", 32'(rsp_err), 32'(ex.e));
          end
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_outputs", {au_en, ac, a, b, rsp_valid, rsp_data, rsp_gf, rsp_err, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) send(4'h1, i, 0, 8'h00);

    send(4'h0, 0, 0, 8'h05);
    send(4'h0, 1, 0, 8'h03);
    send(4'h9, 1, 0, 8'h00);
    send(4'h0, 1, 0, 8'h03);
    send(4'h9, 0, 1, 8'h00);
    send(4'h8, 0, 1, 8'h00);
    send(4'h0, 2, 0, 8'hFF);
    send(4'h0, 3, 0, 8'h02);
    send(4'h8, 2, 3, 8'h00);
    send(4'hD, 0, 3, 8'h00);
    send(4'h1, 0, 0, 8'h00);
    force_stall = 1;
    send(4'h7, 0, 1, 8'hAA);
    for (int i = 0; i < 4; i++) send(4'h1, i, 0, 8'h00);
    send(4'h9, 1, 1, 8'h00);
    send(4'h8, 2, 3, 8'h00, 1);
    send(4'h1, 2, 0, 8'h00);

    for (int n = 0; n < 150; n++)
      send(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)));

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
